// File: rtl/alu_share_arb.sv
// Two-requester front end for a single shared combinational ALU.
// Round-robin arbitration, one operation per cycle, one registered response slot per requester.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [3:0]       req_cntr_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic [WIDTH-1:0] rsp_result_0,
  output logic             rsp_z_0,
  output logic             rsp_o_0,
  output logic             rsp_err_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [3:0]       req_cntr_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_result_1,
  output logic             rsp_z_1,
  output logic             rsp_o_1,
  output logic             rsp_err_1
);

  // Handshakes: a request transfers when req_valid && req_ready at a rising edge;
  // a response transfers when rsp_valid && rsp_ready at a rising edge.

  logic             rsp_valid_0_q, rsp_valid_0_d;
  logic             rsp_valid_1_q, rsp_valid_1_d;
  logic [WIDTH-1:0] rsp_result_0_q, rsp_result_1_q;
  logic             rsp_z_0_q, rsp_o_0_q, rsp_err_0_q;
  logic             rsp_z_1_q, rsp_o_1_q, rsp_err_1_q;
  logic             last_gnt_q, last_gnt_d;

  logic             elig_0, elig_1;
  logic [1:0]       gnt;

  logic [3:0]       alu_cntr;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic             alu_z, alu_o, alu_err, alu_legal;

  // A port may take a new operation only if its response slot is empty or draining now.
  assign elig_0 = req_valid_0 & (~rsp_valid_0_q | rsp_ready_0);
  assign elig_1 = req_valid_1 & (~rsp_valid_1_q | rsp_ready_1);

  always_comb begin
    gnt = 2'b00;
    if (elig_0 && elig_1) begin
      gnt = last_gnt_q ? 2'b01 : 2'b10;
    end else begin
      gnt = {elig_1, elig_0};
    end
    if (!rst_n) begin
      gnt = 2'b00;
    end
  end

  assign req_ready_0 = gnt[0];
  assign req_ready_1 = gnt[1];

  assign alu_cntr = gnt[1] ? req_cntr_1 : req_cntr_0;
  assign alu_a    = gnt[1] ? req_a_1    : req_a_0;
  assign alu_b    = gnt[1] ? req_b_1    : req_b_0;

  assign alu_legal = alu_cntr[3] | (alu_cntr[2:0] == 3'b100);

  always_comb begin
    alu_res = '0;
    alu_o   = 1'b0;
    alu_err = 1'b0;
    if (!alu_legal) begin
      alu_err = 1'b1;
    end else begin
      case (alu_cntr[2:0])
        3'b000:  alu_res = alu_a + alu_b;
        3'b001:  alu_res = alu_a & alu_b;
        3'b010:  alu_res = alu_a ^ alu_b;
        3'b011:  alu_res = alu_a | alu_b;
        3'b100:  alu_res = alu_a - alu_b;
        3'b101:  alu_res = alu_a << alu_b;
        3'b110:  alu_res = alu_a >> alu_b;
        default: alu_res = $signed(alu_a) >>> alu_b;
      endcase
      if (alu_cntr[2:0] == 3'b100) begin
        alu_o = alu_cntr[3] ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b);
      end
    end
  end

  assign alu_z = alu_legal & (alu_res == '0);

  // A new grant reloads the slot in the same cycle it drains, so there is no bubble.
  assign rsp_valid_0_d = gnt[0] | (rsp_valid_0_q & ~rsp_ready_0);
  assign rsp_valid_1_d = gnt[1] | (rsp_valid_1_q & ~rsp_ready_1);
  assign last_gnt_d    = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last_gnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_0_q  <= 1'b0;
      rsp_valid_1_q  <= 1'b0;
      last_gnt_q     <= 1'b1;
      rsp_result_0_q <= '0;
      rsp_z_0_q      <= 1'b0;
      rsp_o_0_q      <= 1'b0;
      rsp_err_0_q    <= 1'b0;
      rsp_result_1_q <= '0;
      rsp_z_1_q      <= 1'b0;
      rsp_o_1_q      <= 1'b0;
      rsp_err_1_q    <= 1'b0;
    end else begin
      rsp_valid_0_q <= rsp_valid_0_d;
      rsp_valid_1_q <= rsp_valid_1_d;
      last_gnt_q    <= last_gnt_d;
      if (gnt[0]) begin
        rsp_result_0_q <= alu_res;
        rsp_z_0_q      <= alu_z;
        rsp_o_0_q      <= alu_o;
        rsp_err_0_q    <= alu_err;
      end
      if (gnt[1]) begin
        rsp_result_1_q <= alu_res;
        rsp_z_1_q      <= alu_z;
        rsp_o_1_q      <= alu_o;
        rsp_err_1_q    <= alu_err;
      end
    end
  end

  assign rsp_valid_0  = rsp_valid_0_q;
  assign rsp_result_0 = rsp_result_0_q;
  assign rsp_z_0      = rsp_z_0_q;
  assign rsp_o_0      = rsp_o_0_q;
  assign rsp_err_0    = rsp_err_0_q;
  assign rsp_valid_1  = rsp_valid_1_q;
  assign rsp_result_1 = rsp_result_1_q;
  assign rsp_z_1      = rsp_z_1_q;
  assign rsp_o_1      = rsp_o_1_q;
  assign rsp_err_1    = rsp_err_1_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed vectors, a cycle-level reference model
// compared every negedge, plus hand-computed literal checks.
module tb_alu_share_arb;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid_0 = 0, req_valid_1 = 0;
  logic         req_ready_0, req_ready_1;
  logic [3:0]   req_cntr_0 = 0, req_cntr_1 = 0;
  logic [W-1:0] req_a_0 = 0, req_b_0 = 0, req_a_1 = 0, req_b_1 = 0;
  logic         rsp_valid_0, rsp_valid_1;
  logic         rsp_ready_0 = 0, rsp_ready_1 = 0;
  logic [W-1:0] rsp_result_0, rsp_result_1;
  logic         rsp_z_0, rsp_o_0, rsp_err_0, rsp_z_1, rsp_o_1, rsp_err_1;

  alu_share_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_cntr_0(req_cntr_0),
    .req_a_0(req_a_0), .req_b_0(req_b_0), .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
    .rsp_result_0(rsp_result_0), .rsp_z_0(rsp_z_0), .rsp_o_0(rsp_o_0), .rsp_err_0(rsp_err_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_cntr_1(req_cntr_1),
    .req_a_1(req_a_1), .req_b_1(req_b_1), .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
    .rsp_result_1(rsp_result_1), .rsp_z_1(rsp_z_1), .rsp_o_1(rsp_o_1), .rsp_err_1(rsp_err_1)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: what each response slot must hold, from the operation rules
  logic         m_v[2];
  logic [W-1:0] m_res[2];
  logic         m_z[2], m_o[2], m_err[2];
  logic         m_last;

  function automatic logic [W+2:0] alu_model(input logic [3:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         o, e;
    r = 0; o = 0; e = 0;
    if (c == 4'b0100) begin
      r = a - b;
      o = (a < b);
    end else if (c[3] == 1'b0) begin
      e = 1;
    end else begin
      case (c[2:0])
        3'd0: r = a + b;
        3'd1: r = a & b;
        3'd2: r = a ^ b;
        3'd3: r = a | b;
        3'd4: begin r = a - b; o = ($signed(a) < $signed(b)); end
        3'd5: r = (b >= W) ? '0 : (a << b[4:0]);
        3'd6: r = (b >= W) ? '0 : (a >> b[4:0]);
        default: begin
          if (b >= W) r = {W{a[W-1]}};
          else r = W'($signed(a) >>> b[4:0]);
        end
      endcase
    end
    return {e, o, (!e && r == 0), r};
  endfunction

  function automatic logic grant_of(input int p);
    logic e0, e1;
    e0 = req_valid_0 && (!m_v[0] || rsp_ready_0);
    e1 = req_valid_1 && (!m_v[1] || rsp_ready_1);
    if (!rst_n) return 1'b0;
    if (e0 && e1) return (p == 0) ? (m_last == 1'b1) : (m_last == 1'b0);
    return (p == 0) ? e0 : e1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v[0] <= 0; m_v[1] <= 0; m_last <= 1;
      m_res[0] <= 0; m_z[0] <= 0; m_o[0] <= 0; m_err[0] <= 0;
      m_res[1] <= 0; m_z[1] <= 0; m_o[1] <= 0; m_err[1] <= 0;
    end else begin
      if (grant_of(0)) begin
        {m_err[0], m_o[0], m_z[0], m_res[0]} <= alu_model(req_cntr_0, req_a_0, req_b_0);
        m_v[0] <= 1;
      end else if (rsp_ready_0) m_v[0] <= 0;
      if (grant_of(1)) begin
        {m_err[1], m_o[1], m_z[1], m_res[1]} <= alu_model(req_cntr_1, req_a_1, req_b_1);
        m_v[1] <= 1;
      end else if (rsp_ready_1) m_v[1] <= 0;
      if (grant_of(0)) m_last <= 0;
      else if (grant_of(1)) m_last <= 1;
    end
  end

  // compare process: every negedge, DUT against model
  always @(negedge clk) begin
    chk("m_ready0", req_ready_0, grant_of(0));
    chk("m_ready1", req_ready_1, grant_of(1));
    chk("m_valid0", rsp_valid_0, m_v[0]);
    chk("m_valid1", rsp_valid_1, m_v[1]);
    if (m_v[0] || !rst_n) begin
      chk("m_res0", rsp_result_0, m_res[0]);
      chk("m_flags0", {rsp_err_0, rsp_o_0, rsp_z_0}, {m_err[0], m_o[0], m_z[0]});
    end
    if (m_v[1] || !rst_n) begin
      chk("m_res1", rsp_result_1, m_res[1]);
      chk("m_flags1", {rsp_err_1, rsp_o_1, rsp_z_1}, {m_err[1], m_o[1], m_z[1]});
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    req_valid_0 = 0; req_valid_1 = 0;
  endtask

  task automatic set0(input logic v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid_0 = v; req_cntr_0 = c; req_a_0 = a; req_b_0 = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid_1 = v; req_cntr_1 = c; req_a_1 = a; req_b_1 = b;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [1:0] gseq[4];
  logic [W-1:0] held;
  logic seen;

  initial begin
    // reset state
    set0(1, 4'b1000, 1, 1);
    #3;
    chk("rst_ready0", req_ready_0, 1'b0);
    chk("rst_valid0", rsp_valid_0, 1'b0);
    chk("rst_res1", rsp_result_1, '0);
    idle_all();
    @(negedge clk); #2 rst_n = 1;

    // single add on port 0
    step();
    rsp_ready_0 = 1; rsp_ready_1 = 1;
    set0(1, 4'b1000, 5, 7);
    @(negedge clk);
    chk("add_ready0", req_ready_0, 1'b1);
    step(); idle_all();
    chk("add_valid0", rsp_valid_0, 1'b1);
    chk("add_res0", rsp_result_0, 12);
    chk("add_flags0", {rsp_err_0, rsp_o_0, rsp_z_0}, 3'b000);
    step();
    chk("add_drain0", rsp_valid_0, 1'b0);

    // round-robin from reset
    do_reset();
    step();
    set0(1, 4'b1000, 1, 1);
    set1(1, 4'b1100, 32'hFFFF_FFFF, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gseq[i] = {req_ready_1, req_ready_0};
      if (i == 2) begin
        chk("slt_valid1", rsp_valid_1, 1'b1);
        chk("slt_res1", rsp_result_1, 32'hFFFF_FFFE);
        chk("slt_o1", rsp_o_1, 1'b1);
      end
    end
    chk("rr_g0", gseq[0], 2'b01);
    chk("rr_g1", gseq[1], 2'b10);
    chk("rr_g2", gseq[2], 2'b01);
    chk("rr_g3", gseq[3], 2'b10);
    step(); idle_all();
    repeat (2) step();

    // port 1 stalled response, port 0 keeps flowing
    rsp_ready_1 = 0;
    set1(1, 4'b0100, 32'hFFFF_FFFF, 1);
    set0(1, 4'b1001, 32'hF0F0, 32'h0FF0);
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (req_ready_1) seen = 1;
      else step();
    end
    chk("stall_gnt1_seen", seen, 1'b1);
    step();
    set1(1, 4'b1000, 5, 5);
    held = rsp_result_1;
    chk("sltu_res1", held, 32'hFFFF_FFFE);
    chk("sltu_o1", rsp_o_1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready1", req_ready_1, 1'b0);
      chk("stall_ready0", req_ready_0, 1'b1);
      chk("stall_hold1", rsp_result_1, held);
      step();
    end
    rsp_ready_1 = 1;
    @(negedge clk);
    chk("b2b_ready1", req_ready_1, 1'b1);
    step(); idle_all();
    chk("b2b_valid1", rsp_valid_1, 1'b1);
    chk("b2b_res1", rsp_result_1, 10);
    repeat (2) step();

    // illegal code then legal
    set0(1, 4'b0000, 3, 4);
    step();
    set0(1, 4'b1000, 0, 0);
    chk("ill_err0", rsp_err_0, 1'b1);
    chk("ill_res0", rsp_result_0, '0);
    chk("ill_z0", rsp_z_0, 1'b0);
    step(); idle_all();
    chk("leg_err0", rsp_err_0, 1'b0);
    chk("leg_z0", rsp_z_0, 1'b1);

    // equal compare, then reset before consume
    step();
    rsp_ready_0 = 0;
    set0(1, 4'b1100, 3, 3);
    step(); idle_all();
    chk("eq_res0", rsp_result_0, '0);
    chk("eq_zo0", {rsp_z_0, rsp_o_0}, 2'b10);
    #2 rst_n = 0;
    #1;
    chk("async_valid0", rsp_valid_0, 1'b0);
    chk("async_z0", rsp_z_0, 1'b0);
    @(negedge clk); #2 rst_n = 1;
    rsp_ready_0 = 1;
    repeat (3) begin
      step();
      chk("post_rst_valid0", rsp_valid_0, 1'b0);
    end

    // continuous port-0 stream
    for (int k = 0; k < 8; k++) begin
      set0(1, 4'b1000, k, 100);
      @(negedge clk);
      chk("strm_ready0", req_ready_0, 1'b1);
      if (k > 0) begin
        chk("strm_valid0", rsp_valid_0, 1'b1);
        chk("strm_res0", rsp_result_0, k - 1 + 100);
      end
      step();
    end
    idle_all();
    chk("strm_last0", rsp_result_0, 107);

    // shifts with oversized amount through port 1
    set1(1, 4'b1111, 32'h8000_0000, 40);
    step(); idle_all();
    chk("sra_big1", rsp_result_1, 32'hFFFF_FFFF);
    set1(1, 4'b1101, 32'h0000_0003, 4);
    step(); idle_all();
    chk("sll1", rsp_result_1, 32'h30);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
